// File: rtl/ats21_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ats21_pkg : shared types and field positions for the ATS21 front end |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ats21_pkg;

   typedef enum logic [2:0] {
      OP_NOP     = 3'b000,
      OP_SET_CLK = 3'b001,
      OP_TOG_BC  = 3'b010,
      OP_MODE    = 3'b011,
      OP_RSVD    = 3'b100,
      OP_SET_ALM = 3'b101,
      OP_SET_CD  = 3'b110,
      OP_TOG_AT  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      STAT_NONE = 2'b00,
      STAT_OK   = 2'b01,
      STAT_DENY = 2'b10,
      STAT_ERR  = 2'b11
   } stat_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CAP_LO = 2'd1,
      S_ARB    = 2'd2,
      S_ISSUE  = 2'd3
   } state_e;

   // Bit positions inside the high instruction half-word
   localparam int c_OPC_MSB  = 15;
   localparam int c_OPC_LSB  = 13;
   localparam int c_ACT_BIT  = 12;
   localparam int c_AT_MSB   = 11;
   localparam int c_AT_LSB   = 10;
   localparam int c_BC_MSB   = 9;
   localparam int c_BC_LSB   = 8;

   localparam logic c_CLIENT_A = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ats21_perm_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ats21_perm_check : classifies a granted opcode against mode regs     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ats21_perm_check
   import ats21_pkg::*;
(
   input  opcode_e    opcode_i,
   input  logic       client_i,
   input  logic       active_i,
   input  logic [1:0] at_perm_i,
   input  logic [1:0] bc_perm_i,
   output logic       pass_o,
   output logic       deny_o,
   output logic       illegal_o,
   output logic       is_mode_o
);

   always_comb begin
      pass_o    = 1'b0;
      deny_o    = 1'b0;
      illegal_o = 1'b0;
      is_mode_o = 1'b0;
      case (opcode_i)
         OP_MODE: begin
            is_mode_o = 1'b1;
            deny_o    = (client_i != c_CLIENT_A);
         end
         OP_SET_CLK, OP_TOG_BC: begin
            pass_o = active_i & bc_perm_i[client_i];
            deny_o = ~(active_i & bc_perm_i[client_i]);
         end
         OP_SET_ALM, OP_SET_CD, OP_TOG_AT: begin
            pass_o = active_i & at_perm_i[client_i];
            deny_o = ~(active_i & at_perm_i[client_i]);
         end
         // NOP is never pending, so it only lands here defensively
         default: illegal_o = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ats21_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ats21_cmd_arbiter : captures, checks and round-robin issues ATS21    |
// | client instructions to the core.                     Rev 1.0         |
// +----------------------------------------------------------------------+
module ats21_cmd_arbiter
   import ats21_pkg::*;
#(
   parameter logic [1:0] RST_AT_PERM = 2'b11,
   parameter logic [1:0] RST_BC_PERM = 2'b11,
   parameter int         STALL_LIMIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [15:0] ctrlA,
   input  logic [15:0] ctrlB,
   output logic        ready,
   output logic        req_drop,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_word,
   output logic        cmd_client,
   output logic [1:0]  stat,
   output logic        stat_client,
   output logic        mode_active
);

   localparam int c_CNT_W = $clog2(STALL_LIMIT + 1);

   state_e            state_q, state_d;
   logic [1:0][15:0]  hi_q, lo_q;
   logic [1:0]        pend_q, pend_d;
   logic              rr_q, rr_d;
   logic              gnt_q, gnt_d;
   logic [31:0]       cmd_word_q, cmd_word_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   stat_e             stat_q, stat_d;
   logic              stat_client_q, stat_client_d;
   logic              active_q, active_d;
   logic [1:0]        at_perm_q, at_perm_d;
   logic [1:0]        bc_perm_q, bc_perm_d;
   logic              req_drop_q;

   logic              w_gnt, w_other;
   opcode_e           w_opcode;
   logic              w_pass, w_deny, w_illegal, w_is_mode;
   logic              w_timeout;
   logic [1:0]        w_cap_pend;

   assign w_gnt      = pend_q[rr_q] ? rr_q : ~rr_q;
   assign w_other    = ~w_gnt;
   assign w_opcode   = opcode_e'(hi_q[w_gnt][c_OPC_MSB:c_OPC_LSB]);
   assign w_timeout  = (cnt_q == c_CNT_W'(STALL_LIMIT - 1));
   assign w_cap_pend = {(hi_q[1][c_OPC_MSB:c_OPC_LSB] != 3'b000),
                        (hi_q[0][c_OPC_MSB:c_OPC_LSB] != 3'b000)};

   ats21_perm_check u_perm_check (
      .opcode_i  (w_opcode),
      .client_i  (w_gnt),
      .active_i  (active_q),
      .at_perm_i (at_perm_q),
      .bc_perm_i (bc_perm_q),
      .pass_o    (w_pass),
      .deny_o    (w_deny),
      .illegal_o (w_illegal),
      .is_mode_o (w_is_mode)
   );

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      rr_d          = rr_q;
      gnt_d         = gnt_q;
      cmd_word_d    = cmd_word_q;
      cnt_d         = cnt_q;
      stat_d        = STAT_NONE;
      stat_client_d = stat_client_q;
      active_d      = active_q;
      at_perm_d     = at_perm_q;
      bc_perm_d     = bc_perm_q;
      case (state_q)
         S_IDLE: begin
            if (req) state_d = S_CAP_LO;
         end
         S_CAP_LO: begin
            pend_d  = w_cap_pend;
            state_d = (|w_cap_pend) ? S_ARB : S_IDLE;
         end
         S_ARB: begin
            if (w_pass) begin
               gnt_d      = w_gnt;
               cmd_word_d = {hi_q[w_gnt], lo_q[w_gnt]};
               cnt_d      = '0;
               state_d    = S_ISSUE;
            end else begin
               // Mode writes land this edge, before the other client is checked
               if (w_is_mode && !w_deny) begin
                  active_d  = hi_q[w_gnt][c_ACT_BIT];
                  at_perm_d = hi_q[w_gnt][c_AT_MSB:c_AT_LSB];
                  bc_perm_d = hi_q[w_gnt][c_BC_MSB:c_BC_LSB];
               end
               if (w_deny)         stat_d = STAT_DENY;
               else if (w_illegal) stat_d = STAT_ERR;
               else                stat_d = STAT_OK;
               stat_client_d  = w_gnt;
               pend_d[w_gnt]  = 1'b0;
               rr_d           = w_other;
               state_d        = pend_q[w_other] ? S_ARB : S_IDLE;
            end
         end
         S_ISSUE: begin
            if (cmd_ready || w_timeout) begin
               stat_d         = cmd_ready ? STAT_OK : STAT_ERR;
               stat_client_d  = gnt_q;
               pend_d[gnt_q]  = 1'b0;
               rr_d           = ~gnt_q;
               cmd_word_d     = '0;
               state_d        = pend_q[~gnt_q] ? S_ARB : S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         hi_q          <= '0;
         lo_q          <= '0;
         pend_q        <= '0;
         rr_q          <= c_CLIENT_A;
         gnt_q         <= c_CLIENT_A;
         cmd_word_q    <= '0;
         cnt_q         <= '0;
         stat_q        <= STAT_NONE;
         stat_client_q <= 1'b0;
         active_q      <= 1'b1;
         at_perm_q     <= RST_AT_PERM;
         bc_perm_q     <= RST_BC_PERM;
         req_drop_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         rr_q          <= rr_d;
         gnt_q         <= gnt_d;
         cmd_word_q    <= cmd_word_d;
         cnt_q         <= cnt_d;
         stat_q        <= stat_d;
         stat_client_q <= stat_client_d;
         active_q      <= active_d;
         at_perm_q     <= at_perm_d;
         bc_perm_q     <= bc_perm_d;
         req_drop_q    <= req && (state_q != S_IDLE);
         if (state_q == S_IDLE && req) hi_q <= {ctrlB, ctrlA};
         if (state_q == S_CAP_LO)      lo_q <= {ctrlB, ctrlA};
      end
   end

   assign ready       = (state_q == S_IDLE);
   assign cmd_valid   = (state_q == S_ISSUE);
   assign cmd_word    = cmd_word_q;
   assign cmd_client  = gnt_q;
   assign stat        = stat_q;
   assign stat_client = stat_client_q;
   assign req_drop    = req_drop_q;
   assign mode_active = active_q;

endmodule
`default_nettype wire

// File: tb/tb_ats21_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ats21_cmd_arbiter : directed self-checking bench for the arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ats21_cmd_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [15:0] ctrlA = '0;
   logic [15:0] ctrlB = '0;
   logic        ready, req_drop, cmd_valid, cmd_client, stat_client, mode_active;
   logic        cmd_ready = 1'b1;
   logic [31:0] cmd_word;
   logic [1:0]  stat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ats21_cmd_arbiter #(
      .RST_AT_PERM (2'b11),
      .RST_BC_PERM (2'b11),
      .STALL_LIMIT (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .ctrlA       (ctrlA),
      .ctrlB       (ctrlB),
      .ready       (ready),
      .req_drop    (req_drop),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_word    (cmd_word),
      .cmd_client  (cmd_client),
      .stat        (stat),
      .stat_client (stat_client),
      .mode_active (mode_active)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 1'b0; ctrlA = '0; ctrlB = '0; cmd_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Returns one cycle after the low word was presented (arbiter now in ARB)
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      req = 1'b1; ctrlA = a[31:16]; ctrlB = b[31:16];
      tick();
      req = 1'b0; ctrlA = a[15:0]; ctrlB = b[15:0];
      tick();
      ctrlA = '0; ctrlB = '0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (ready !== 1'b1)     begin bad++; $display("FAIL rst_ready got=%b exp=1", ready); end
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", cmd_valid); end
      total++; if (cmd_word !== 32'h0) begin bad++; $display("FAIL rst_word got=%h exp=0", cmd_word); end
      total++; if (stat !== 2'b00)     begin bad++; $display("FAIL rst_stat got=%b exp=00", stat); end
      total++; if (req_drop !== 1'b0)  begin bad++; $display("FAIL rst_drop got=%b exp=0", req_drop); end
      total++; if (mode_active !== 1'b1) begin bad++; $display("FAIL rst_active got=%b exp=1", mode_active); end
   endtask

   task automatic test_single_issue();
      do_reset();
      send(32'h2200_0000, 32'h0);
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0", cmd_valid); end
      tick();
      total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", cmd_valid); end
      total++; if (cmd_word !== 32'h2200_0000) begin bad++; $display("FAIL t1_word got=%h exp=22000000", cmd_word); end
      total++; if (cmd_client !== 1'b0) begin bad++; $display("FAIL t1_client got=%b exp=0", cmd_client); end
      tick();
      total++; if (stat !== 2'b01)      begin bad++; $display("FAIL t1_stat got=%b exp=01", stat); end
      total++; if (stat_client !== 1'b0) begin bad++; $display("FAIL t1_stat_client got=%b exp=0", stat_client); end
      total++; if (cmd_valid !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL t1_idle valid=%b ready=%b exp 0/1", cmd_valid, ready); end
      tick();
      total++; if (stat !== 2'b00)      begin bad++; $display("FAIL t1_stat_pulse got=%b exp=00", stat); end
   endtask

   task automatic test_round_robin();
      do_reset();
      send(32'h2040_0000, 32'h2280_0000);
      tick();
      total++; if (cmd_valid !== 1'b1 || cmd_client !== 1'b0 || cmd_word !== 32'h2040_0000)
         begin bad++; $display("FAIL t2_first v=%b c=%b w=%h exp 1/0/20400000", cmd_valid, cmd_client, cmd_word); end
      tick();
      total++; if (stat !== 2'b01 || stat_client !== 1'b0 || cmd_valid !== 1'b0)
         begin bad++; $display("FAIL t2_first_stat s=%b sc=%b v=%b exp 01/0/0", stat, stat_client, cmd_valid); end
      tick();
      total++; if (cmd_valid !== 1'b1 || cmd_client !== 1'b1 || cmd_word !== 32'h2280_0000)
         begin bad++; $display("FAIL t2_second v=%b c=%b w=%h exp 1/1/22800000", cmd_valid, cmd_client, cmd_word); end
      tick();
      total++; if (stat !== 2'b01 || stat_client !== 1'b1 || ready !== 1'b1)
         begin bad++; $display("FAIL t2_second_stat s=%b sc=%b r=%b exp 01/1/1", stat, stat_client, ready); end
      // A lone A grant leaves the pointer on B for the next dual request
      send(32'h2200_0000, 32'h0);
      tick(); tick();
      send(32'h2040_0000, 32'h2280_0000);
      tick();
      total++; if (cmd_valid !== 1'b1 || cmd_client !== 1'b1 || cmd_word !== 32'h2280_0000)
         begin bad++; $display("FAIL t2_rr_flip v=%b c=%b w=%h exp 1/1/22800000", cmd_valid, cmd_client, cmd_word); end
   endtask

   task automatic test_mode_deny();
      do_reset();
      send(32'h6400_0000, 32'h0);
      tick();
      total++; if (stat !== 2'b01 || stat_client !== 1'b0)
         begin bad++; $display("FAIL t3_mode_stat s=%b sc=%b exp 01/0", stat, stat_client); end
      total++; if (mode_active !== 1'b0) begin bad++; $display("FAIL t3_mode_active got=%b exp=0", mode_active); end
      total++; if (cmd_valid !== 1'b0)   begin bad++; $display("FAIL t3_mode_valid got=%b exp=0", cmd_valid); end
      send(32'h0, 32'hA000_0045);
      tick();
      total++; if (stat !== 2'b10 || stat_client !== 1'b1 || cmd_valid !== 1'b0)
         begin bad++; $display("FAIL t3_deny s=%b sc=%b v=%b exp 10/1/0", stat, stat_client, cmd_valid); end
      // Mode write from B is refused and leaves the regs alone
      send(32'h0, 32'h7F00_0000);
      tick();
      total++; if (stat !== 2'b10 || mode_active !== 1'b0)
         begin bad++; $display("FAIL t3_modeB s=%b act=%b exp 10/0", stat, mode_active); end
   endtask

   task automatic test_illegal();
      do_reset();
      send(32'h8000_0000, 32'h0);
      tick();
      total++; if (stat !== 2'b11 || stat_client !== 1'b0)
         begin bad++; $display("FAIL t4_illegal s=%b sc=%b exp 11/0", stat, stat_client); end
      total++; if (cmd_valid !== 1'b0 || ready !== 1'b1)
         begin bad++; $display("FAIL t4_idle v=%b r=%b exp 0/1", cmd_valid, ready); end
   endtask

   task automatic test_stall_timeout();
      int hi_cycles;
      do_reset();
      cmd_ready = 1'b0;
      send(32'h2200_0000, 32'h0);
      hi_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cmd_valid === 1'b1) hi_cycles++;
      end
      total++; if (hi_cycles != 4) begin bad++; $display("FAIL t5_valid_cycles got=%0d exp=4", hi_cycles); end
      tick();
      total++; if (cmd_valid !== 1'b0 || stat !== 2'b11 || stat_client !== 1'b0)
         begin bad++; $display("FAIL t5_timeout v=%b s=%b sc=%b exp 0/11/0", cmd_valid, stat, stat_client); end
      cmd_ready = 1'b1;
   endtask

   task automatic test_drop_and_reset();
      do_reset();
      // A keeps bc permission, B loses it
      send(32'h7100_0000, 32'h0);
      tick();
      cmd_ready = 1'b0;
      send(32'h2200_0000, 32'h0);
      tick();
      req = 1'b1; ctrlA = 16'hE000; ctrlB = 16'hE000;
      tick();
      req = 1'b0; ctrlA = '0; ctrlB = '0;
      total++; if (req_drop !== 1'b1) begin bad++; $display("FAIL t6_req_drop got=%b exp=1", req_drop); end
      total++; if (cmd_valid !== 1'b1 || cmd_word !== 32'h2200_0000)
         begin bad++; $display("FAIL t6_no_capture v=%b w=%h exp 1/22000000", cmd_valid, cmd_word); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cmd_ready = 1'b1;
      total++; if (cmd_valid !== 1'b0 || ready !== 1'b1 || stat !== 2'b00 || mode_active !== 1'b1)
         begin bad++; $display("FAIL t6_reset v=%b r=%b s=%b act=%b exp 0/1/00/1", cmd_valid, ready, stat, mode_active); end
      send(32'h0, 32'h2200_0000);
      tick();
      total++; if (cmd_valid !== 1'b1 || cmd_client !== 1'b1)
         begin bad++; $display("FAIL t6_bc_perm_reset v=%b c=%b exp 1/1", cmd_valid, cmd_client); end
   endtask

   initial begin
      test_reset();
      test_single_issue();
      test_round_robin();
      test_mode_deny();
      test_illegal();
      test_stall_timeout();
      test_drop_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
